// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the serial packed-BCD adder.
//   state_t  : controller states (idle, per-digit add, one-cycle done)
//   DIGIT_W  : width of one BCD digit
//   BCD_MAX  : largest legal decimal digit value
//   BCD_ADJ  : correction added to a binary digit sum that overflows 9
package bcd_serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int         DIGIT_W = 4;
   localparam logic [4:0] BCD_MAX = 5'd9;
   localparam logic [4:0] BCD_ADJ = 5'd6;

endpackage

// File: rtl/bcd_serial_adder_digit_add.sv
// Single decimal digit adder, purely combinational.
// Ports:
//   a, b   : BCD digits (0..9 expected)
//   cin    : decimal carry in
//   digit  : BCD sum digit
//   cout   : decimal carry out
module bcd_digit_add
   import bcd_serial_adder_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               cin,
   output logic [DIGIT_W-1:0] digit,
   output logic               cout
);

   logic [4:0] raw;
   logic [4:0] adj;

   always_comb begin
      raw   = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      adj   = raw + BCD_ADJ;
      digit = raw[3:0];
      cout  = 1'b0;
      // Sums 10..19 wrap past the six unused binary codes.
      if (raw > BCD_MAX) begin
         digit = adj[3:0];
         cout  = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock, LSB digit first.
// Ports:
//   clk, reset        : rising-edge clock, async active-high reset
//   start             : request, sampled only while idle
//   a, b, cin         : operands (digit 0 in bits [3:0]) and carry in,
//                       sampled with an accepted start
//   busy              : high while an operation is in progress
//   done              : one-cycle pulse, result valid from this cycle
//   sum, cout         : packed BCD result and decimal carry out, held
//   invalid           : an operand digit was above 9, no add performed
module bcd_serial_adder
   import bcd_serial_adder_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [4*DIGITS-1:0]       a,
   input  logic [4*DIGITS-1:0]       b,
   input  logic                      cin,
   output logic                      busy,
   output logic                      done,
   output logic [4*DIGITS-1:0]       sum,
   output logic                      cout,
   output logic                      invalid
);

   localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_t state_q, state_d;

   logic [DIGITS-1:0][DIGIT_W-1:0] a_q, b_q, sum_q;
   logic                           carry_q, cout_q, invalid_q;
   logic [IDX_W-1:0]               idx_q;
   logic [DIGIT_W-1:0]             dig;
   logic                           carry_nx;
   logic                           ops_ok;

   function automatic logic all_bcd(input logic [4*DIGITS-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if ({1'b0, v[i*DIGIT_W +: DIGIT_W]} > BCD_MAX) ok = 1'b0;
      end
      return ok;
   endfunction

   assign ops_ok = all_bcd(a) && all_bcd(b);

   bcd_digit_add u_digit (
      .a     (a_q[idx_q]),
      .b     (b_q[idx_q]),
      .cin   (carry_q),
      .digit (dig),
      .cout  (carry_nx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ops_ok ? ST_ADD : ST_DONE;
         ST_ADD:  if (idx_q == LAST_IDX) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         cout_q    <= 1'b0;
         invalid_q <= 1'b0;
         idx_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_q       <= a;
                  b_q       <= b;
                  carry_q   <= cin;
                  sum_q     <= '0;
                  cout_q    <= 1'b0;
                  invalid_q <= !ops_ok;
                  idx_q     <= '0;
               end
            end
            ST_ADD: begin
               sum_q[idx_q] <= dig;
               carry_q      <= carry_nx;
               if (idx_q == LAST_IDX) cout_q <= carry_nx;
               else                   idx_q  <= idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);
   assign sum     = sum_q;
   assign cout    = cout_q;
   assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

   localparam int DIGITS = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        busy, done, cout, invalid;
   logic [15:0] sum;

   int n_vec = 0;
   int n_bad = 0;
   int done_cnt = 0;

   bcd_serial_adder #(.DIGITS(DIGITS)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .cin     (cin),
      .busy    (busy),
      .done    (done),
      .sum     (sum),
      .cout    (cout),
      .invalid (invalid)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        inv;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Edges counted from the start edge inclusive until done is seen high.
   task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, output int lat);
      @(negedge clk);
      a = va; b = vb; cin = vc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = ~va; b = ~vb; cin = ~vc;
      lat = 1;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int base;

      vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 5};
      vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5};
      vecs[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 5};
      vecs[3] = '{16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1};
      vecs[4] = '{16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 5};
      vecs[5] = '{16'h4567, 16'h5433, 1'b0, 16'h0000, 1'b1, 1'b0, 5};
      vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 5};
      vecs[7] = '{16'h0009, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1, 1};

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_inv", invalid, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_sum", i), sum, vecs[i].sum);
         chk($sformatf("v%0d_cout", i), cout, vecs[i].cout);
         chk($sformatf("v%0d_inv", i), invalid, vecs[i].inv);
         chk($sformatf("v%0d_busy_at_done", i), busy, 1);
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_drop", i), done, 0);
         chk($sformatf("v%0d_idle", i), busy, 0);
      end

      // Start pulsed while busy must be ignored.
      base = done_cnt;
      @(negedge clk);
      a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("busy_start_sum", sum, 16'h0002);
      chk("busy_start_cout", cout, 0);
      chk("busy_start_done_pulses", done_cnt - base, 1);
      chk("busy_start_idle", busy, 0);

      // Reset in the middle of an add.
      base = done_cnt;
      @(negedge clk);
      a = 16'h5555; b = 16'h5555; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midop_partial_sum", sum, 16'h0010);
      chk("midop_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_sum", sum, 0);
      chk("abort_cout", cout, 0);
      chk("abort_inv", invalid, 0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("abort_no_done", done_cnt - base, 0);
      run_op(16'h0003, 16'h0004, 1'b0, lat);
      chk("post_rst_latency", lat, 5);
      chk("post_rst_sum", sum, 16'h0007);
      chk("post_rst_cout", cout, 0);

      // Result holds while inputs wander with start low.
      @(posedge clk); #1;
      for (int k = 0; k < 10; k++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         cin = 1'($urandom);
         @(posedge clk); #1;
         chk($sformatf("hold%0d_sum", k), sum, 16'h0007);
         chk($sformatf("hold%0d_cout", k), cout, 0);
         chk($sformatf("hold%0d_inv", k), invalid, 0);
         chk($sformatf("hold%0d_busy", k), busy, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
